motor_step_gen_mc: RTL and testbench
====================================

MOTOR_STEP_GEN_MC -- requirements
Module: motor_step_gen_mc

Interface
REQ-001 Parameters SHALL be: CH_NUM, default 2, number of independent step/dir channels (1..8).
REQ-002 Parameters SHALL be: CNT_W, default 24, width of step-count and position fields.
REQ-003 Parameters SHALL be: DIV_W, default 16, width of the half-period divider.
REQ-004 Parameters SHALL be: DIR_SETUP, default 4, clk cycles between dirction change and first step edge.
REQ-005 Ports SHALL be: clk  in  1  single system clock; all logic on its rising edge.
REQ-006 Ports SHALL be: rst  in  1  asynchronous, active-high reset.
REQ-007 Ports SHALL be: cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-008 Ports SHALL be: cmd_ch  in  max(1,clog2(CH_NUM))  target channel; cmd_dir  in  1  direction (0 = toward limit/home).
REQ-009 Ports SHALL be: cmd_steps  in  CNT_W  steps to issue; cmd_half_period  in  DIV_W  step high/low time in clk cycles.
REQ-010 Ports SHALL be: abort  in  CH_NUM  per-channel stop request; limit_signal  in  CH_NUM  filtered, synchronous, active-high home limit.
REQ-011 Ports SHALL be: step, dirction, coe_enable, busy  out  CH_NUM each  pulse, direction, driver enable, channel active.
REQ-012 Ports SHALL be: done  out  CH_NUM  one-cycle completion pulse; limit_hit  out  CH_NUM  sticky status, cleared on next accepted command.
REQ-013 Ports SHALL be: pos_o  out  CH_NUM*CNT_W  signed per-channel position, channel n at bits [n*CNT_W +: CNT_W] (present only per REQ-029).

Function
REQ-014 cmd_ready SHALL be combinationally high when the channel selected by cmd_ch is IDLE and cmd_ch < CH_NUM.
REQ-015 A command SHALL be accepted on a clk edge with cmd_valid && cmd_ready; cmd_dir, cmd_steps and max(cmd_half_period,1) latch into that channel.
REQ-016 Each channel SHALL run the FSM IDLE -> SETUP -> HIGH <-> LOW -> IDLE.
REQ-017 On accept: dirction, coe_enable=1, busy=1 the next cycle; SETUP lasts exactly DIR_SETUP cycles; step rises on the first HIGH cycle.
REQ-018 HIGH and LOW SHALL each last exactly half_period cycles; one step is counted per HIGH entry; after the cmd_steps-th LOW phase the channel enters IDLE.
REQ-019 On IDLE entry from a run: done pulses one cycle, busy=0, step=0; coe_enable and dirction retain their values.
REQ-020 cmd_steps = 0 SHALL skip SETUP: IDLE for one cycle after accept, done pulses, no step edge.
REQ-021 limit_signal[n]=1 with dirction[n]=0 in SETUP, HIGH or LOW SHALL force step low next cycle, set limit_hit, pulse done, enter IDLE; limit with dirction=1 SHALL be ignored.
REQ-022 abort[n] SHALL behave as REQ-021 without setting limit_hit; abort has priority when simultaneous with limit, and is ignored in IDLE.
REQ-023 A command accepted with cmd_dir=0 while limit_signal is already high SHALL set limit_hit and complete after DIR_SETUP with zero steps.
REQ-024 Channels SHALL be fully independent; a command to one channel never delays another.
REQ-025 Counters SHALL not wrap: step counter down-counts from cmd_steps to 0, divider reloads each phase.

Reset
REQ-026 While rst=1 all outputs SHALL be 0, all FSMs IDLE, pos_o 0, limit_hit 0, asynchronously.
REQ-027 Reset asserted mid-run SHALL abort immediately with no done pulse; after release cmd_ready follows REQ-014 on the first edge.

Configuration
REQ-028 Macro MOTOR_POS_CNT_EN SHALL control the position counter.
REQ-029 Defined: pos_o increments on each step rise with dirction=1, decrements with dirction=0, and clears to 0 when limit_hit is set; undefined: pos_o is tied to 0 and no counter logic exists.

Verification
REQ-030 CH_NUM=2, ch0 dir=1 steps=3 half=2 -> step high cycles 5-6, 9-10, 13-14 after accept, done at cycle 17, pos_o ch0=3.
REQ-031 ch0 dir=0 steps=100 half=5, limit high after 4th step rise -> step low next cycle, limit_hit=1, done pulse, pos_o ch0=0.
REQ-032 ch1 steps=10, abort[1] during 2nd HIGH -> step low next cycle, done pulse, limit_hit=0, 2 steps counted.
REQ-033 cmd_valid to busy ch0 -> cmd_ready=0, command ignored; simultaneous command to ch1 accepted and runs concurrently.
REQ-034 steps=0 -> done one cycle after IDLE re-entry, no step edge; half_period=0 -> behaves as half_period=1.
REQ-035 rst pulsed mid-run -> all outputs 0 within the reset, no done pulse, new command accepted after release.

Source files
------------

// File: rtl/motor_step_gen_mc.sv
// Multi-channel step/direction pulse generator.
// Each channel runs IDLE -> SETUP -> HIGH <-> LOW -> IDLE from a latched command.
// Optional feature: define MOTOR_POS_CNT_EN to build the signed per-channel
// position counter on pos_o. When it is undefined, pos_o is tied to zero.
module motor_step_gen_mc #(
    parameter int CH_NUM    = 2,
    parameter int CNT_W     = 24,
    parameter int DIV_W     = 16,
    parameter int DIR_SETUP = 4,
    localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_ch,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [DIV_W-1:0]        cmd_half_period,
    input  logic [CH_NUM-1:0]       abort,
    input  logic [CH_NUM-1:0]       limit_signal,
    output logic [CH_NUM-1:0]       step,
    output logic [CH_NUM-1:0]       dirction,
    output logic [CH_NUM-1:0]       coe_enable,
    output logic [CH_NUM-1:0]       busy,
    output logic [CH_NUM-1:0]       done,
    output logic [CH_NUM-1:0]       limit_hit,
    output logic [CH_NUM*CNT_W-1:0] pos_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    localparam logic [DIV_W-1:0] SETUP_LOAD = DIV_W'(DIR_SETUP - 1);

    logic [CH_NUM-1:0] w_idle;
    logic              w_ready;

    // A command is accepted only when it addresses an existing, idle channel.
    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (cmd_ch == CH_W'(i) && w_idle[i]) begin
                w_ready = 1'b1;
            end
        end
    end

    // Outputs must read zero for the whole reset, including the ready flag.
    assign cmd_ready = w_ready & ~rst;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        state_t           r_state;
        state_t           w_nstate;
        logic             r_dir;
        logic             r_en;
        logic             r_done;
        logic             r_lim_hit;
        logic             r_lim_pend;
        logic [CNT_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_half;
        logic [DIV_W-1:0] w_half_in;
        logic             w_acc;
        logic             w_lim_now;
        logic             w_stop;
        logic             w_lim_stop;
        logic             w_lim_set;
        logic             w_done_n;
        logic             w_step_rise;

        assign w_acc     = cmd_valid && cmd_ready && (cmd_ch == CH_W'(n));
        assign w_half_in = (cmd_half_period == '0) ? DIV_W'(1) : cmd_half_period;
        // A limit already present at accept is reported at the end of SETUP
        // instead of cutting SETUP short.
        assign w_lim_now  = limit_signal[n] && !r_dir && !r_lim_pend;
        assign w_stop     = (r_state != S_IDLE) && (abort[n] || w_lim_now);
        assign w_lim_stop = (r_state != S_IDLE) && !abort[n] && w_lim_now;
        assign w_lim_set  = (w_acc && !cmd_dir && limit_signal[n]) || w_lim_stop;
        assign w_step_rise = (w_nstate == S_HIGH) && (r_state != S_HIGH);

        // Next-state and completion-pulse decode.
        always_comb begin
            w_nstate = r_state;
            w_done_n = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (cmd_steps == '0) w_done_n = 1'b1;
                        else                 w_nstate = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_stop || (r_div == '0 && r_lim_pend)) begin
                        w_nstate = S_IDLE;
                        w_done_n = 1'b1;
                    end else if (r_div == '0) begin
                        w_nstate = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_stop) begin
                        w_nstate = S_IDLE;
                        w_done_n = 1'b1;
                    end else if (r_div == '0) begin
                        w_nstate = S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_stop || (r_div == '0 && r_cnt == '0)) begin
                        w_nstate = S_IDLE;
                        w_done_n = 1'b1;
                    end else if (r_div == '0) begin
                        w_nstate = S_HIGH;
                    end
                end
                default: w_nstate = S_IDLE;
            endcase
        end

        // State register plus latched command, divider and step counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= S_IDLE;
                r_dir      <= 1'b0;
                r_en       <= 1'b0;
                r_done     <= 1'b0;
                r_lim_hit  <= 1'b0;
                r_lim_pend <= 1'b0;
                r_cnt      <= '0;
                r_div      <= '0;
                r_half     <= '0;
            end else begin
                r_state <= w_nstate;
                r_done  <= w_done_n;
                if (w_acc) begin
                    r_dir      <= cmd_dir;
                    r_en       <= 1'b1;
                    r_half     <= w_half_in;
                    r_lim_pend <= !cmd_dir && limit_signal[n];
                    r_lim_hit  <= w_lim_set;
                end else if (w_lim_stop) begin
                    r_lim_hit  <= 1'b1;
                end
                if (w_acc)            r_cnt <= cmd_steps;
                else if (w_step_rise) r_cnt <= r_cnt - CNT_W'(1);
                if (r_state == S_IDLE && w_nstate == S_SETUP)
                    r_div <= SETUP_LOAD;
                else if (w_nstate != r_state && w_nstate != S_IDLE)
                    r_div <= r_half - DIV_W'(1);
                else if (r_div != '0)
                    r_div <= r_div - DIV_W'(1);
            end
        end

        assign w_idle[n]     = (r_state == S_IDLE);
        assign step[n]       = (r_state == S_HIGH);
        assign busy[n]       = (r_state != S_IDLE);
        assign dirction[n]   = r_dir;
        assign coe_enable[n] = r_en;
        assign done[n]       = r_done;
        assign limit_hit[n]  = r_lim_hit;

`ifdef MOTOR_POS_CNT_EN
        logic signed [CNT_W-1:0] r_pos;

        // Position follows step rises; a limit hit re-homes it to zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)              r_pos <= '0;
            else if (w_lim_set)   r_pos <= '0;
            else if (w_step_rise) r_pos <= r_dir ? r_pos + CNT_W'(1) : r_pos - CNT_W'(1);
        end

        assign pos_o[n*CNT_W +: CNT_W] = r_pos;
`else
        assign pos_o[n*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_motor_step_gen_mc.sv
// Scoreboard bench for motor_step_gen_mc (two channels, default parameters).
module tb_motor_step_gen_mc;

    localparam int CH_NUM    = 2;
    localparam int CNT_W     = 24;
    localparam int DIV_W     = 16;
    localparam int DIR_SETUP = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [0:0]              cmd_ch;
    logic                    cmd_dir;
    logic [CNT_W-1:0]        cmd_steps;
    logic [DIV_W-1:0]        cmd_half_period;
    logic [CH_NUM-1:0]       abort;
    logic [CH_NUM-1:0]       limit_signal;
    logic [CH_NUM-1:0]       step;
    logic [CH_NUM-1:0]       dirction;
    logic [CH_NUM-1:0]       coe_enable;
    logic [CH_NUM-1:0]       busy;
    logic [CH_NUM-1:0]       done;
    logic [CH_NUM-1:0]       limit_hit;
    logic [CH_NUM*CNT_W-1:0] pos_o;

    motor_step_gen_mc #(
        .CH_NUM(CH_NUM), .CNT_W(CNT_W), .DIV_W(DIV_W), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half_period(cmd_half_period),
        .abort(abort), .limit_signal(limit_signal),
        .step(step), .dirction(dirction), .coe_enable(coe_enable), .busy(busy),
        .done(done), .limit_hit(limit_hit), .pos_o(pos_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base;
        int lat;
        int steps;
        int h;
        bit lim;
    } sb_t;

    sb_t        q0[$];
    sb_t        q1[$];
    int         n_tot = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         nr[2];
    int         last_rise[2];
    logic [1:0] prev_step = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int heff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int run_lat(input int steps, input int h);
        return (steps == 0) ? 1 : DIR_SETUP + 2 * heff(h) * steps + 1;
    endfunction

    // Per-channel monitor: step rise timing, high width, completion checks.
    task automatic mon(input int ch);
        sb_t e;
        bit  have;
        bit  rise;
        bit  fall;
        have = (ch == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (ch == 0) ? q0[0] : q1[0];
        rise = step[ch] && !prev_step[ch];
        fall = !step[ch] && prev_step[ch];
        if (rise) begin
            if (!have) check("unexp_step", 1, 0);
            else begin
                check("rise_ofs", cyc - e.base, DIR_SETUP + 1 + nr[ch] * 2 * e.h);
                nr[ch]++;
            end
            last_rise[ch] = cyc;
        end
        if (fall && !done[ch] && have) check("high_len", cyc - last_rise[ch], e.h);
        if (done[ch]) begin
            if (!have) check("unexp_done", 1, 0);
            else begin
                check("done_lat", cyc - e.base, e.lat);
                check("step_cnt", nr[ch], e.steps);
                check("limit_hit", limit_hit[ch], e.lim);
                if (ch == 0) void'(q0.pop_front());
                else         void'(q1.pop_front());
            end
            nr[ch] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
        prev_step = step;
    end

    // Drive one command at a negedge; push the expectation if it should be taken.
    task automatic send(input int ch, input bit dir, input int steps, input int half,
                        input bit exp_rdy, input int exp_steps, input int exp_lat,
                        input bit exp_lim, output int base);
        sb_t e;
        cmd_ch          = 1'(ch);
        cmd_dir         = dir;
        cmd_steps       = CNT_W'(steps);
        cmd_half_period = DIV_W'(half);
        cmd_valid       = 1'b1;
        base            = cyc;
        #1;
        check("cmd_ready", cmd_ready, exp_rdy);
        if (exp_rdy) begin
            e = '{base, exp_lat, exp_steps, heff(half), exp_lim};
            if (ch == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            check("timeout", 0, 1);
            q0.delete();
            q1.delete();
            nr[0] = 0;
            nr[1] = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b1;
        nr[0] = 0; nr[1] = 0; last_rise[0] = 0; last_rise[1] = 0;
        cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        cmd_half_period = '0; abort = '0; limit_signal = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coe", coe_enable, 0);
        check("rst_dir", dirction, 0);
        check("rst_limhit", limit_hit, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        #1 check("ready_after_rst", cmd_ready, 1);
        @(negedge clk);

        // Basic run on ch0, direction 1.
        send(0, 1, 3, 2, 1, 3, run_lat(3, 2), 0, b);
        check("run_busy", busy[0], 1);
        check("run_coe", coe_enable[0], 1);
        check("run_dir", dirction[0], 1);
        check("setup_step", step[0], 0);
        wait_idle();
        check("end_busy", busy[0], 0);
        check("end_coe", coe_enable[0], 1);
        check("end_dir", dirction[0], 1);
`ifdef MOTOR_POS_CNT_EN
        check("pos0", longint'($signed(pos_o[CNT_W-1:0])), 3);
`else
        check("pos0", pos_o, 0);
`endif

        // Zero steps, then zero half period.
        send(1, 1, 0, 3, 1, 0, 1, 0, b);
        wait_idle();
        send(1, 0, 2, 0, 1, 2, run_lat(2, 0), 0, b);
        wait_idle();

        // Limit toward home after the 4th step rise.
        send(0, 0, 100, 5, 1, 4, DIR_SETUP + 1 + 30 + 1, 1, b);
        while (cyc - b < DIR_SETUP + 1 + 30) @(negedge clk);
        limit_signal[0] = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        check("limhit_sticky", limit_hit[0], 1);

        // Command toward home while limit already active.
        send(0, 0, 5, 3, 1, 0, DIR_SETUP + 1, 1, b);
        check("pre_limhit", limit_hit[0], 1);
        wait_idle();
        limit_signal[0] = 1'b0;
        send(0, 1, 1, 1, 1, 1, run_lat(1, 1), 0, b);
        check("limhit_clear", limit_hit[0], 0);
        wait_idle();

        // Limit ignored when moving away from home.
        limit_signal[1] = 1'b1;
        send(1, 1, 2, 1, 1, 2, run_lat(2, 1), 0, b);
        wait_idle();
        limit_signal[1] = 1'b0;

        // Abort in the 2nd HIGH on ch1.
        send(1, 1, 10, 3, 1, 2, DIR_SETUP + 1 + 6 + 1, 0, b);
        while (cyc - b < DIR_SETUP + 1 + 6) @(negedge clk);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        wait_idle();

        // Abort and limit together: abort wins, no limit_hit.
        send(0, 0, 10, 2, 1, 2, DIR_SETUP + 1 + 4 + 1, 0, b);
        while (cyc - b < DIR_SETUP + 1 + 4) @(negedge clk);
        abort[0] = 1'b1;
        limit_signal[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        limit_signal[0] = 1'b0;
        wait_idle();

        // Abort while idle has no effect.
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_idle_done", done[0], 0);
        check("abort_idle_busy", busy[0], 0);

        // Busy channel refuses; other channel runs concurrently.
        send(0, 1, 20, 2, 1, 20, run_lat(20, 2), 0, b);
        send(0, 1, 5, 1, 0, 0, 0, 0, b);
        send(1, 1, 3, 1, 1, 3, run_lat(3, 1), 0, b1);
        check("concurrent_busy", busy, 2'b11);
        wait_idle();

        // Reset in the middle of a run.
        send(0, 1, 50, 3, 1, 50, run_lat(50, 3), 0, b);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_step", step, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_coe", coe_enable, 0);
        check("mid_rst_dir", dirction, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", cmd_ready, 0);
        q0.delete();
        nr[0] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_done", done, 0);
        send(0, 1, 2, 2, 1, 2, run_lat(2, 2), 0, b);
        wait_idle();

        check("sb_empty", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
